// File: rtl/instruction_decode_pipelined_pkg.sv
// Shared constants for the ID stage: forward-select codes, opcodes and the bubble encoding.
package id_pkg;

  // Operand source select, in the encoding the EX-side tooling expects.
  typedef enum logic [1:0] {
    FWD_BANK   = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2,
    FWD_ID_EX  = 2'd3
  } fwd_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // A bubble is the all-zero instruction (sll r0,r0,0 == NOP).
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // rt is a true source only for R-type, compare-branches and stores;
  // for loads and immediates it is the destination.
  function automatic logic uses_rt(input logic [5:0] op);
    logic used;
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: used = 1'b1;
      OP_LW:                           used = 1'b0;
      default:                         used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/instruction_decode_pipelined_hazard_unit.sv
// Combinational hazard detection and operand forward selection for the ID stage.
module hazard_unit
  import id_pkg::*;
#(
  parameter int SIZE_REG_DIR = 5,
  parameter int SIZE_OP      = 6
) (
  input  logic                    i_valid,
  input  logic [SIZE_OP-1:0]      op,
  input  logic [SIZE_REG_DIR-1:0] rs,
  input  logic [SIZE_REG_DIR-1:0] rt,
  input  logic [SIZE_REG_DIR-1:0] rd_id_ex,
  input  logic [SIZE_REG_DIR-1:0] rd_ex_mem,
  input  logic [SIZE_REG_DIR-1:0] rd_mem_wb,
  input  logic                    reg_wr_id_ex,
  input  logic                    reg_wr_ex_mem,
  input  logic                    reg_wr_mem_wb,
  input  logic                    mem_read_id_ex,
  input  logic                    mem_read_ex_mem,
  output logic                    hz,
  output fwd_sel_e                sel_a,
  output fwd_sel_e                sel_b
);

  logic [SIZE_REG_DIR-1:0] src [2];
  fwd_sel_e                sel [2];
  logic [1:0]              src_used;
  logic [1:0]              load_use_hit;
  logic [1:0]              br_alu_hit;
  logic [1:0]              br_load_hit;
  logic                    branch_op;

  assign src[0]    = rs;
  assign src[1]    = rt;
  assign branch_op = is_branch(op);
  assign src_used  = {uses_rt(op), 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // Nearest producer wins; a load still in ID/EX has no data yet so it is skipped.
      assign sel[gi] = (src[gi] == '0)                                        ? FWD_BANK   :
                       (reg_wr_id_ex && !mem_read_id_ex && rd_id_ex == src[gi]) ? FWD_ID_EX  :
                       (reg_wr_ex_mem && rd_ex_mem == src[gi])                  ? FWD_EX_MEM :
                       (reg_wr_mem_wb && rd_mem_wb == src[gi])                  ? FWD_MEM_WB :
                                                                                  FWD_BANK;

      assign load_use_hit[gi] = src_used[gi] && mem_read_id_ex &&
                                (rd_id_ex != '0) && (rd_id_ex == src[gi]);
      // Branches resolve in ID, so an ALU result still in EX is one cycle too late.
      assign br_alu_hit[gi]   = branch_op && reg_wr_id_ex && (rd_id_ex == src[gi]);
      // A load in MEM only has data at the end of the cycle; the branch must wait for WB.
      assign br_load_hit[gi]  = branch_op && mem_read_ex_mem && (rd_ex_mem == src[gi]);
    end
  endgenerate

  assign hz    = i_valid && ((|load_use_hit) || (|br_alu_hit) || (|br_load_hit));
  assign sel_a = sel[0];
  assign sel_b = sel[1];

endmodule

// File: rtl/instruction_decode_pipelined.sv
// MIPS ID stage: decode, register bank, forwarding, hazard stalls, branch resolution,
// ID/EX pipeline register and a saturating stall counter.
module instruction_decode_pipelined
  import id_pkg::*;
#(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS),
  parameter int SIZE_OP       = 6,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIZE-1:0]         i_instruction,
  input  logic                    i_valid,
  input  logic [SIZE-1:0]         i_pc_plus4,
  input  logic                    i_flush,
  input  logic                    i_ex_stall,
  input  logic                    i_write_enable,
  input  logic [SIZE_REG_DIR-1:0] i_w_dir,
  input  logic [SIZE-1:0]         i_w_data,
  input  logic [SIZE_REG_DIR-1:0] i_rd_id_ex,
  input  logic [SIZE_REG_DIR-1:0] i_rd_ex_mem,
  input  logic [SIZE_REG_DIR-1:0] i_rd_mem_wb,
  input  logic                    i_reg_wr_id_ex,
  input  logic                    i_reg_wr_ex_mem,
  input  logic                    i_reg_wr_mem_wb,
  input  logic                    i_mem_read_id_ex,
  input  logic                    i_mem_read_ex_mem,
  input  logic [SIZE-1:0]         i_data_id_ex,
  input  logic [SIZE-1:0]         i_data_ex_mem,
  input  logic [SIZE-1:0]         i_data_mem_wb,
  output logic                    o_stall_if,
  output logic                    o_branch_taken,
  output logic [SIZE-1:0]         o_branch_target,
  output logic                    o_valid,
  output logic [SIZE_OP-1:0]      o_op,
  output logic [5:0]              o_funct,
  output logic [SIZE-1:0]         o_reg_A,
  output logic [SIZE-1:0]         o_reg_B,
  output logic [SIZE-1:0]         o_immediate,
  output logic [SIZE_REG_DIR-1:0] o_dir_rs,
  output logic [SIZE_REG_DIR-1:0] o_dir_rt,
  output logic [SIZE_REG_DIR-1:0] o_dir_rd,
  output logic [CNT_WIDTH-1:0]    o_stall_count
);

  typedef struct packed {
    logic                    valid;
    logic [SIZE_OP-1:0]      op;
    logic [5:0]              funct;
    logic [SIZE-1:0]         reg_a;
    logic [SIZE-1:0]         reg_b;
    logic [SIZE-1:0]         imm;
    logic [SIZE_REG_DIR-1:0] rs;
    logic [SIZE_REG_DIR-1:0] rt;
    logic [SIZE_REG_DIR-1:0] rd;
  } idex_t;

  // ---------------- decode ----------------
  logic [SIZE_OP-1:0]      op;
  logic [5:0]              funct;
  logic [SIZE_REG_DIR-1:0] rs;
  logic [SIZE_REG_DIR-1:0] rt;
  logic [SIZE_REG_DIR-1:0] rd;
  logic [SIZE-1:0]         imm_ext;
  logic                    unused_shamt;

  assign op           = i_instruction[SIZE-1 -: SIZE_OP];
  assign rs           = i_instruction[21 +: SIZE_REG_DIR];
  assign rt           = i_instruction[16 +: SIZE_REG_DIR];
  assign rd           = i_instruction[11 +: SIZE_REG_DIR];
  assign funct        = i_instruction[5:0];
  assign imm_ext      = {{(SIZE-16){i_instruction[15]}}, i_instruction[15:0]};
  assign unused_shamt = ^i_instruction[10:6];

  // ---------------- register bank ----------------
  logic [SIZE-1:0] bank_reg [NUM_REGISTERS];

  // Register bank write port; r0 is hard-wired to zero by never being written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++) bank_reg[i] <= '0;
    end else if (i_write_enable && (i_w_dir != '0)) begin
      bank_reg[i_w_dir] <= i_w_data;
    end
  end

  // ---------------- hazards and forwarding ----------------
  logic     hz;
  fwd_sel_e sel_a;
  fwd_sel_e sel_b;

  hazard_unit #(
    .SIZE_REG_DIR (SIZE_REG_DIR),
    .SIZE_OP      (SIZE_OP)
  ) u_hazard_unit (
    .i_valid         (i_valid),
    .op              (op),
    .rs              (rs),
    .rt              (rt),
    .rd_id_ex        (i_rd_id_ex),
    .rd_ex_mem       (i_rd_ex_mem),
    .rd_mem_wb       (i_rd_mem_wb),
    .reg_wr_id_ex    (i_reg_wr_id_ex),
    .reg_wr_ex_mem   (i_reg_wr_ex_mem),
    .reg_wr_mem_wb   (i_reg_wr_mem_wb),
    .mem_read_id_ex  (i_mem_read_id_ex),
    .mem_read_ex_mem (i_mem_read_ex_mem),
    .hz              (hz),
    .sel_a           (sel_a),
    .sel_b           (sel_b)
  );

  logic [SIZE_REG_DIR-1:0] src_dir [2];
  fwd_sel_e                fwd_sel [2];
  logic [SIZE-1:0]         operand [2];

  assign src_dir[0] = rs;
  assign src_dir[1] = rt;
  assign fwd_sel[0] = sel_a;
  assign fwd_sel[1] = sel_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign operand[gi] = (fwd_sel[gi] == FWD_ID_EX)  ? i_data_id_ex  :
                           (fwd_sel[gi] == FWD_EX_MEM) ? i_data_ex_mem :
                           (fwd_sel[gi] == FWD_MEM_WB) ? i_data_mem_wb :
                                                         bank_reg[src_dir[gi]];
    end
  endgenerate

  // ---------------- branch resolution ----------------
  logic operands_equal;
  assign operands_equal  = (operand[0] == operand[1]);
  assign o_branch_taken  = i_valid && !hz && !i_ex_stall &&
                           (((op == OP_BEQ) && operands_equal) ||
                            ((op == OP_BNE) && !operands_equal));
  assign o_branch_target = i_pc_plus4 + {imm_ext[SIZE-3:0], 2'b00};
  assign o_stall_if      = hz || i_ex_stall;

  // ---------------- ID/EX register ----------------
  idex_t idex_reg;
  idex_t idex_next;
  idex_t idex_decoded;
  idex_t idex_bubble;

  // Decoded record and the bubble record (the NOP instruction decoded with zero operands).
  always_comb begin
    idex_decoded       = '0;
    idex_decoded.valid = i_valid;
    idex_decoded.op    = op;
    idex_decoded.funct = funct;
    idex_decoded.reg_a = operand[0];
    idex_decoded.reg_b = operand[1];
    idex_decoded.imm   = imm_ext;
    idex_decoded.rs    = rs;
    idex_decoded.rt    = rt;
    idex_decoded.rd    = rd;

    idex_bubble        = '0;
    idex_bubble.op     = BUBBLE_INSTR[31 -: SIZE_OP];
    idex_bubble.funct  = BUBBLE_INSTR[5:0];
    idex_bubble.imm    = {{(SIZE-16){BUBBLE_INSTR[15]}}, BUBBLE_INSTR[15:0]};
    idex_bubble.rs     = BUBBLE_INSTR[21 +: SIZE_REG_DIR];
    idex_bubble.rt     = BUBBLE_INSTR[16 +: SIZE_REG_DIR];
    idex_bubble.rd     = BUBBLE_INSTR[11 +: SIZE_REG_DIR];
  end

  // Next ID/EX contents: flush beats a downstream stall, which beats a local hazard.
  always_comb begin
    idex_next = idex_reg;
    if (i_flush)         idex_next = idex_bubble;
    else if (i_ex_stall) idex_next = idex_reg;
    else if (hz)         idex_next = idex_bubble;
    else                 idex_next = idex_decoded;
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_reg <= '0;
    else      idex_reg <= idex_next;
  end

  // ---------------- stall counter ----------------
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;

  // Count only cycles this stage itself stalls; a downstream stall is not our hazard.
  always_comb begin
    cnt_next = cnt_reg;
    if (hz && !i_ex_stall && (cnt_reg != '1)) cnt_next = cnt_reg + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_reg <= '0;
    else      cnt_reg <= cnt_next;
  end

  assign o_valid       = idex_reg.valid;
  assign o_op          = idex_reg.op;
  assign o_funct       = idex_reg.funct;
  assign o_reg_A       = idex_reg.reg_a;
  assign o_reg_B       = idex_reg.reg_b;
  assign o_immediate   = idex_reg.imm;
  assign o_dir_rs      = idex_reg.rs;
  assign o_dir_rt      = idex_reg.rt;
  assign o_dir_rd      = idex_reg.rd;
  assign o_stall_count = cnt_reg;

endmodule

// File: tb/tb_instruction_decode_pipelined.sv
// Self-checking bench for the ID stage: directed sequences, a vector table and
// randomized cycles against a value-level reference model.
module tb_instruction_decode_pipelined;

  localparam int CNT_W = 8;

  logic        clk;
  logic        rst;
  logic [31:0] i_instruction;
  logic        i_valid;
  logic [31:0] i_pc_plus4;
  logic        i_flush;
  logic        i_ex_stall;
  logic        i_write_enable;
  logic [4:0]  i_w_dir;
  logic [31:0] i_w_data;
  logic [4:0]  i_rd_id_ex, i_rd_ex_mem, i_rd_mem_wb;
  logic        i_reg_wr_id_ex, i_reg_wr_ex_mem, i_reg_wr_mem_wb;
  logic        i_mem_read_id_ex, i_mem_read_ex_mem;
  logic [31:0] i_data_id_ex, i_data_ex_mem, i_data_mem_wb;
  logic        o_stall_if, o_branch_taken, o_valid;
  logic [31:0] o_branch_target, o_reg_A, o_reg_B, o_immediate;
  logic [5:0]  o_op, o_funct;
  logic [4:0]  o_dir_rs, o_dir_rt, o_dir_rd;
  logic [CNT_W-1:0] o_stall_count;

  instruction_decode_pipelined #(.CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_instruction(i_instruction), .i_valid(i_valid), .i_pc_plus4(i_pc_plus4),
    .i_flush(i_flush), .i_ex_stall(i_ex_stall),
    .i_write_enable(i_write_enable), .i_w_dir(i_w_dir), .i_w_data(i_w_data),
    .i_rd_id_ex(i_rd_id_ex), .i_rd_ex_mem(i_rd_ex_mem), .i_rd_mem_wb(i_rd_mem_wb),
    .i_reg_wr_id_ex(i_reg_wr_id_ex), .i_reg_wr_ex_mem(i_reg_wr_ex_mem),
    .i_reg_wr_mem_wb(i_reg_wr_mem_wb),
    .i_mem_read_id_ex(i_mem_read_id_ex), .i_mem_read_ex_mem(i_mem_read_ex_mem),
    .i_data_id_ex(i_data_id_ex), .i_data_ex_mem(i_data_ex_mem), .i_data_mem_wb(i_data_mem_wb),
    .o_stall_if(o_stall_if), .o_branch_taken(o_branch_taken),
    .o_branch_target(o_branch_target), .o_valid(o_valid), .o_op(o_op), .o_funct(o_funct),
    .o_reg_A(o_reg_A), .o_reg_B(o_reg_B), .o_immediate(o_immediate),
    .o_dir_rs(o_dir_rs), .o_dir_rt(o_dir_rt), .o_dir_rd(o_dir_rd),
    .o_stall_count(o_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_flight();
    i_rd_id_ex = '0;  i_rd_ex_mem = '0;  i_rd_mem_wb = '0;
    i_reg_wr_id_ex = 0; i_reg_wr_ex_mem = 0; i_reg_wr_mem_wb = 0;
    i_mem_read_id_ex = 0; i_mem_read_ex_mem = 0;
    i_data_id_ex = '0; i_data_ex_mem = '0; i_data_mem_wb = '0;
  endtask

  task automatic clear_inputs();
    i_instruction = '0; i_valid = 0; i_pc_plus4 = '0; i_flush = 0; i_ex_stall = 0;
    i_write_enable = 0; i_w_dir = '0; i_w_data = '0;
    clear_flight();
  endtask

  task automatic wr_reg(input logic [4:0] dir, input logic [31:0] data);
    i_write_enable = 1; i_w_dir = dir; i_w_data = data;
    tick();
    i_write_enable = 0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, rd;
  } idex_m_t;

  idex_m_t     m;
  logic [31:0] mbank [32];
  int          m_cnt;

  // Value an operand register holds as seen by ID, nearest in-flight producer first.
  function automatic logic [31:0] m_value(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (i_reg_wr_id_ex && !i_mem_read_id_ex && i_rd_id_ex == r) return i_data_id_ex;
    if (i_reg_wr_ex_mem && i_rd_ex_mem == r) return i_data_ex_mem;
    if (i_reg_wr_mem_wb && i_rd_mem_wb == r) return i_data_mem_wb;
    return mbank[r];
  endfunction

  function automatic bit m_hazard();
    logic [5:0] op = i_instruction[31:26];
    logic [4:0] rs = i_instruction[25:21];
    logic [4:0] rt = i_instruction[20:16];
    bit br   = (op == 6'd4) || (op == 6'd5);
    bit r_rt = (op == 6'd0) || br || (op == 6'd43);
    bit lu, ba, bl;
    lu = i_mem_read_id_ex && i_rd_id_ex != 0 && (i_rd_id_ex == rs || (r_rt && i_rd_id_ex == rt));
    ba = br && i_reg_wr_id_ex && (i_rd_id_ex == rs || i_rd_id_ex == rt);
    bl = br && i_mem_read_ex_mem && (i_rd_ex_mem == rs || i_rd_ex_mem == rt);
    return i_valid && (lu || ba || bl);
  endfunction

  task automatic model_reset();
    m = '{valid: 0, op: 0, funct: 0, a: 0, b: 0, imm: 0, rs: 0, rt: 0, rd: 0};
    m_cnt = 0;
    for (int i = 0; i < 32; i++) mbank[i] = '0;
  endtask

  task automatic check_model_regs();
    check("valid", 32'(o_valid), 32'(m.valid));
    check("op", 32'(o_op), 32'(m.op));
    check("funct", 32'(o_funct), 32'(m.funct));
    check("reg_A", o_reg_A, m.a);
    check("reg_B", o_reg_B, m.b);
    check("imm", o_immediate, m.imm);
    check("dirs", {17'd0, o_dir_rs, o_dir_rt, o_dir_rd}, {17'd0, m.rs, m.rt, m.rd});
    check("stall_count", 32'(o_stall_count), 32'(m_cnt));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [4:0]  rd_ie; logic wr_ie; logic mr_ie;
    logic [4:0]  rd_em; logic wr_em; logic mr_em;
    logic        exp_stall;
    logic        exp_taken;
  } vec_t;

  vec_t       vecs [15];
  logic [5:0] op_pool [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 0;
    model_reset();

    // bank holds r1=5 r2=7 r3=5 r4=9; EX/MEM data 5, ID/EX data 0x77
    vecs[0]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h20), 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0};
    vecs[1]  = '{enc_r(5'd4, 5'd1, 5'd5, 6'h20), 1, 5'd4, 1, 1, 5'd0, 0, 0, 1, 0};
    vecs[2]  = '{enc_r(5'd1, 5'd4, 5'd5, 6'h20), 1, 5'd4, 1, 1, 5'd0, 0, 0, 1, 0};
    vecs[3]  = '{enc_i(6'd8, 5'd1, 5'd4, 16'h7), 1, 5'd4, 1, 1, 5'd0, 0, 0, 0, 0};
    vecs[4]  = '{enc_i(6'd43, 5'd1, 5'd4, 16'h0), 1, 5'd4, 1, 1, 5'd0, 0, 0, 1, 0};
    vecs[5]  = '{enc_i(6'd35, 5'd0, 5'd6, 16'h0), 1, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0};
    vecs[6]  = '{enc_i(6'd4, 5'd1, 5'd3, 16'h10), 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1};
    vecs[7]  = '{enc_i(6'd4, 5'd1, 5'd2, 16'h10), 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0};
    vecs[8]  = '{enc_i(6'd5, 5'd1, 5'd2, 16'h10), 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1};
    vecs[9]  = '{enc_i(6'd4, 5'd1, 5'd3, 16'h10), 1, 5'd3, 1, 0, 5'd0, 0, 0, 1, 0};
    vecs[10] = '{enc_i(6'd4, 5'd1, 5'd3, 16'h10), 1, 5'd0, 0, 0, 5'd3, 0, 1, 1, 0};
    vecs[11] = '{enc_i(6'd4, 5'd1, 5'd3, 16'h10), 1, 5'd0, 0, 0, 5'd3, 1, 0, 0, 1};
    vecs[12] = '{enc_r(5'd4, 5'd1, 5'd5, 6'h20), 0, 5'd4, 1, 1, 5'd0, 0, 0, 0, 0};
    vecs[13] = '{enc_i(6'd5, 5'd1, 5'd3, 16'h10), 1, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0};
    vecs[14] = '{enc_i(6'd4, 5'd2, 5'd4, 16'h10), 1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 0};

    op_pool = '{6'd0, 6'd4, 6'd5, 6'd35, 6'd43, 6'd8};

    // ---- reset state ----
    #23;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_count", 32'(o_stall_count), 32'd0);
    @(negedge clk);
    rst = 1;
    tick();

    // ---- capture something, then async reset mid-cycle ----
    i_valid = 1;
    i_instruction = enc_i(6'd8, 5'd2, 5'd1, 16'h1234);
    tick();
    $display("seq reset: before reset valid=%0b op=%0h imm=%0h", o_valid, o_op, o_immediate);
    check("pre_reset_valid", 32'(o_valid), 32'd1);
    check("pre_reset_imm", o_immediate, 32'h1234);
    #2 rst = 0;
    #1;
    check("async_reset_valid", 32'(o_valid), 32'd0);
    check("async_reset_op", 32'(o_op), 32'd0);
    check("async_reset_imm", o_immediate, 32'd0);
    check("async_reset_dir_rt", 32'(o_dir_rt), 32'd0);
    rst = 1;
    i_valid = 0;
    wr_reg(5'd1, 32'd5);
    wr_reg(5'd2, 32'd7);
    i_valid = 1;
    i_instruction = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    #1 check("add_no_stall", 32'(o_stall_if), 32'd0);
    tick();
    $display("seq add: A=%0d B=%0d valid=%0b", o_reg_A, o_reg_B, o_valid);
    check("add_reg_A", o_reg_A, 32'd5);
    check("add_reg_B", o_reg_B, 32'd7);
    check("add_valid", 32'(o_valid), 32'd1);
    check("add_rd", 32'(o_dir_rd), 32'd3);

    // ---- load-use: one stall, then EX/MEM forward ----
    i_instruction = enc_r(5'd4, 5'd1, 5'd5, 6'h20);
    i_mem_read_id_ex = 1; i_rd_id_ex = 5'd4; i_reg_wr_id_ex = 1; i_data_id_ex = 32'hDEAD;
    #1 check("lu_stall", 32'(o_stall_if), 32'd1);
    tick();
    check("lu_bubble", 32'(o_valid), 32'd0);
    check("lu_count", 32'(o_stall_count), 32'd1);
    clear_flight();
    i_rd_ex_mem = 5'd4; i_reg_wr_ex_mem = 1; i_mem_read_ex_mem = 1; i_data_ex_mem = 32'h1234;
    #1 check("lu_release", 32'(o_stall_if), 32'd0);
    tick();
    $display("seq load-use: A=%0h B=%0h count=%0d", o_reg_A, o_reg_B, o_stall_count);
    check("lu_fwd_A", o_reg_A, 32'h1234);
    check("lu_fwd_B", o_reg_B, 32'd5);
    check("lu_valid", 32'(o_valid), 32'd1);

    // ---- BEQ after LW: two stalls then taken ----
    clear_flight();
    i_instruction = enc_i(6'd4, 5'd4, 5'd4, 16'hFFFF);
    i_pc_plus4 = 32'h104;
    i_mem_read_id_ex = 1; i_rd_id_ex = 5'd4; i_reg_wr_id_ex = 1;
    #1 check("beq_stall1", 32'(o_stall_if), 32'd1);
    check("beq_not_taken1", 32'(o_branch_taken), 32'd0);
    tick();
    clear_flight();
    i_mem_read_ex_mem = 1; i_rd_ex_mem = 5'd4; i_reg_wr_ex_mem = 1;
    #1 check("beq_stall2", 32'(o_stall_if), 32'd1);
    check("beq_not_taken2", 32'(o_branch_taken), 32'd0);
    tick();
    clear_flight();
    i_rd_mem_wb = 5'd4; i_reg_wr_mem_wb = 1; i_data_mem_wb = 32'h55;
    #1 check("beq_go", 32'(o_stall_if), 32'd0);
    check("beq_taken", 32'(o_branch_taken), 32'd1);
    check("beq_target", o_branch_target, 32'h100);
    tick();
    $display("seq beq: op=%0h A=%0h count=%0d", o_op, o_reg_A, o_stall_count);
    check("beq_count", 32'(o_stall_count), 32'd3);
    check("beq_reg_A", o_reg_A, 32'h55);

    // ---- forwarding priority and r0 ----
    clear_flight();
    i_rd_ex_mem = 5'd7; i_reg_wr_ex_mem = 1; i_data_ex_mem = 32'hAA;
    i_rd_mem_wb = 5'd7; i_reg_wr_mem_wb = 1; i_data_mem_wb = 32'hBB;
    i_rd_id_ex = 5'd0;  i_reg_wr_id_ex = 1;  i_data_id_ex = 32'h99;
    i_instruction = enc_r(5'd7, 5'd0, 5'd8, 6'h20);
    tick();
    $display("seq fwd: A=%0h B=%0h", o_reg_A, o_reg_B);
    check("fwd_exmem_priority", o_reg_A, 32'hAA);
    check("fwd_r0_zero", o_reg_B, 32'd0);

    // ---- downstream stall holds ID/EX and counter ----
    clear_flight();
    i_instruction = enc_r(5'd4, 5'd1, 5'd5, 6'h20);
    i_mem_read_id_ex = 1; i_rd_id_ex = 5'd4; i_reg_wr_id_ex = 1;
    i_ex_stall = 1;
    for (int c = 0; c < 3; c++) begin
      #1 check("exstall_stall_if", 32'(o_stall_if), 32'd1);
      tick();
      $display("seq ex_stall cycle %0d: A=%0h count=%0d", c, o_reg_A, o_stall_count);
      check("exstall_hold_A", o_reg_A, 32'hAA);
      check("exstall_hold_valid", 32'(o_valid), 32'd1);
      check("exstall_count", 32'(o_stall_count), 32'd3);
    end
    i_flush = 1;
    tick();
    check("flush_over_stall", 32'(o_valid), 32'd0);
    i_flush = 0; i_ex_stall = 0;

    // ---- saturation of the stall counter (hazard still present) ----
    for (int c = 0; c < (1 << CNT_W) + 2; c++) tick();
    $display("seq saturate: count=%0d", o_stall_count);
    check("count_saturated", 32'(o_stall_count), 32'((1 << CNT_W) - 1));

    // ---- vector table ----
    clear_flight();
    i_valid = 0;
    wr_reg(5'd3, 32'd5);
    wr_reg(5'd4, 32'd9);
    i_data_ex_mem = 32'd5;
    i_data_id_ex  = 32'h77;
    for (int v = 0; v < 15; v++) begin
      i_instruction = vecs[v].instr;   i_valid = vecs[v].valid;
      i_rd_id_ex = vecs[v].rd_ie;      i_reg_wr_id_ex = vecs[v].wr_ie;
      i_mem_read_id_ex = vecs[v].mr_ie;
      i_rd_ex_mem = vecs[v].rd_em;     i_reg_wr_ex_mem = vecs[v].wr_em;
      i_mem_read_ex_mem = vecs[v].mr_em;
      #1;
      $display("vec %0d: instr=%08h stall=%0b taken=%0b", v, i_instruction, o_stall_if, o_branch_taken);
      check($sformatf("vec%0d_stall", v), 32'(o_stall_if), 32'(vecs[v].exp_stall));
      check($sformatf("vec%0d_taken", v), 32'(o_branch_taken), 32'(vecs[v].exp_taken));
    end

    // ---- randomized cycles against the model ----
    clear_inputs();
    #2 rst = 0;
    #2 rst = 1;
    model_reset();
    tick();
    for (int t = 0; t < 400; t++) begin
      logic [5:0]  rop;
      logic [15:0] rimm;
      logic [31:0] ea, eb, exp_target;
      bit          ehz, etaken;
      int          off;
      rop  = op_pool[$urandom_range(0, 5)];
      rimm = 16'($urandom);
      i_instruction = {rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom)};
      i_instruction[15:0] = (rop == 6'd0) ? i_instruction[15:0] : rimm;
      i_valid = ($urandom_range(0, 7) != 0);
      i_pc_plus4 = $urandom;
      i_flush = ($urandom_range(0, 15) == 0);
      i_ex_stall = ($urandom_range(0, 7) == 0);
      i_write_enable = $urandom_range(0, 1);
      i_w_dir = 5'($urandom_range(0, 7));
      i_w_data = $urandom;
      i_rd_id_ex = 5'($urandom_range(0, 7));
      i_rd_ex_mem = 5'($urandom_range(0, 7));
      i_rd_mem_wb = 5'($urandom_range(0, 7));
      i_reg_wr_id_ex = $urandom_range(0, 1);
      i_reg_wr_ex_mem = $urandom_range(0, 1);
      i_reg_wr_mem_wb = $urandom_range(0, 1);
      i_mem_read_id_ex = ($urandom_range(0, 3) == 0);
      i_mem_read_ex_mem = ($urandom_range(0, 3) == 0);
      i_data_id_ex = $urandom; i_data_ex_mem = $urandom; i_data_mem_wb = $urandom;
      #1;
      ehz = m_hazard();
      ea  = m_value(i_instruction[25:21]);
      eb  = m_value(i_instruction[20:16]);
      etaken = i_valid && !ehz && !i_ex_stall &&
               ((rop == 6'd4 && ea == eb) || (rop == 6'd5 && ea != eb));
      off = 4 * int'($signed(i_instruction[15:0]));
      exp_target = i_pc_plus4 + 32'(off);
      check("rnd_stall_if", 32'(o_stall_if), 32'(ehz || i_ex_stall));
      check("rnd_taken", 32'(o_branch_taken), 32'(etaken));
      check("rnd_target", o_branch_target, exp_target);
      $display("txn %0d: instr=%08h v=%0b fl=%0b xs=%0b hz=%0b taken=%0b",
               t, i_instruction, i_valid, i_flush, i_ex_stall, ehz, etaken);
      // next model state, computed from pre-edge bank contents
      if (i_flush || (!i_ex_stall && ehz)) begin
        m = '{valid: 0, op: 0, funct: 0, a: 0, b: 0, imm: 0, rs: 0, rt: 0, rd: 0};
      end else if (!i_ex_stall) begin
        m.valid = i_valid;
        m.op    = rop;
        m.funct = i_instruction[5:0];
        m.a     = ea;
        m.b     = eb;
        m.imm   = 32'(int'($signed(i_instruction[15:0])));
        m.rs    = i_instruction[25:21];
        m.rt    = i_instruction[20:16];
        m.rd    = i_instruction[15:11];
      end
      if (ehz && !i_ex_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (i_write_enable && i_w_dir != 0) mbank[i_w_dir] = i_w_data;
      tick();
      check_model_regs();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_pipelined.md
Name: instruction_decode_pipelined

Overview:
- Parametrised next-generation MIPS ID stage; sits between the IF/ID and ID/EX boundaries.
- Decodes the instruction, reads the register bank, and forwards operands from ID/EX, EX/MEM and MEM/WB.
- Detects load-use and branch-operand hazards, resolves BEQ/BNE in ID, and owns the ID/EX pipeline register (hold, bubble, flush).
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- SIZE, 32, data/instruction width
- NUM_REGISTERS, 32, register bank depth
- SIZE_REG_DIR, $clog2(NUM_REGISTERS), register address width
- SIZE_OP, 6, opcode width
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_instruction  in  SIZE  IF/ID instruction
- i_valid  in  1  IF/ID entry valid
- i_pc_plus4  in  SIZE  PC+4 of the instruction
- i_flush  in  1  squash ID/EX next edge
- i_ex_stall  in  1  downstream stall; hold ID/EX
- i_write_enable, i_w_dir, i_w_data  in  1/SIZE_REG_DIR/SIZE  register bank write port
- i_rd_id_ex, i_rd_ex_mem, i_rd_mem_wb  in  SIZE_REG_DIR  destinations in flight
- i_reg_wr_id_ex, i_reg_wr_ex_mem, i_reg_wr_mem_wb  in  1  destination write enables
- i_mem_read_id_ex, i_mem_read_ex_mem  in  1  producer is a load
- i_data_id_ex, i_data_ex_mem, i_data_mem_wb  in  SIZE  forwarded values
- o_stall_if  out  1  hold PC and IF/ID
- o_branch_taken  out  1  branch resolved taken
- o_branch_target  out  SIZE  i_pc_plus4 + (sign-extended imm << 2)
- o_valid  out  1  registered: ID/EX entry valid
- o_op  out  SIZE_OP  registered: opcode
- o_funct  out  6  registered: funct
- o_reg_A, o_reg_B  out  SIZE  registered: forwarded operands
- o_immediate  out  SIZE  registered: sign-extended immediate
- o_dir_rs, o_dir_rt, o_dir_rd  out  SIZE_REG_DIR  registered: register fields
- o_stall_count  out  CNT_WIDTH  saturating count of hazard stall cycles

Behaviour:
- Reset (rst=0, async): all registered outputs 0, o_valid=0, o_stall_count=0.
- Forward select per operand, highest priority first:
  - ID/EX: match, reg_wr, not load
  - EX/MEM
  - MEM/WB
  - register bank
- Address 0 never forwards; it always reads 0.
- Select encoding: 0 bank, 1 EX/MEM, 2 MEM/WB, 3 ID/EX.
- Hazards are combinational, re-evaluated every cycle, and are gated by i_valid.
  - "Used" means rs, plus rt for R-type/BEQ/BNE/store.
  - Load-use: i_mem_read_id_ex with nonzero i_rd_id_ex matching a used source.
  - Branch-ALU: BEQ/BNE with a source matching ID/EX and reg_wr_id_ex=1.
  - Branch-load: BEQ/BNE with a source matching EX/MEM and i_mem_read_ex_mem=1.
  - Any hazard -> hz=1.
- Net effect: branch after load stalls 2 cycles; branch after ALU op stalls 1; load-use stalls 1.
- o_stall_if = hz | i_ex_stall.
- ID/EX update priority at each edge:
  - i_flush: load bubble (all 0, o_valid=0).
  - else i_ex_stall: hold.
  - else hz: load bubble.
  - else capture decoded fields and forwarded operands, o_valid=i_valid.
- o_branch_taken = i_valid & !hz & !i_ex_stall & ((BEQ & A==B) | (BNE & A!=B)), using forwarded operands.
  - Opcodes: BEQ=000100, BNE=000101.
  - Combinational, same cycle.
- o_branch_target is wraparound modulo 2^SIZE.
- o_stall_count increments on each cycle with hz=1 & !i_ex_stall; saturates at all-ones.
- Bubble = instruction 0 semantics (NOP): registered fields 0.
- Register bank has no write-through; same-cycle writes are covered by MEM/WB forwarding.

Decomposition:
- Package id_pkg: forward-select constants, opcode constants (BEQ, BNE, LW, SW, R-type), bubble value.
- Sub-module hazard_unit: combinational hz and forward selects.
- Existing register_bank, mux and sign extender are reused.

Test Plan:
- rst low mid-run with o_valid=1 -> all outputs 0 immediately, no clock needed. After release, ADD r3,r1,r2 with r1=5, r2=7 -> next edge o_reg_A=5, o_reg_B=7, o_valid=1.
- LW r4 in ID/EX (mem_read=1, rd=4), ID holds ADD r5,r4,r1 -> o_stall_if=1 for 1 cycle, bubble in ID/EX, o_stall_count=1. Next cycle the ADD proceeds with EX/MEM forward.
- BEQ r4,r4 immediately after LW r4 -> 2 stall cycles, then o_branch_taken=1; o_branch_target=i_pc_plus4+(imm<<2), e.g. 0x104 with imm=0xFFFF -> 0x100.
- r7 written in both EX/MEM (0xAA) and MEM/WB (0xBB), ADD reads r7 -> o_reg_A=0xAA. rd=0 with reg_wr=1 -> operand stays 0.
- i_ex_stall=1 for 3 cycles -> ID/EX held, o_stall_if=1, counter unchanged. i_flush with i_ex_stall together -> o_valid=0 next edge.
- Force 2^CNT_WIDTH+2 hazard cycles -> o_stall_count stays at all-ones.
